seq_lshift_rot: RTL and testbench

- Multi-cycle left shifter/rotator for the project's shift datapath; the left-direction counterpart of the combinational right-shift/arithmetic-shift stages.
- Accepts a 32-bit operand and a 5-bit shift amount on a start pulse.
- Shifts left by 2 bits per clock (1 bit on the final step if the amount is odd), then asserts done for one cycle with the result.
- Serves the ALU's SLL/ROL operations where area matters more than latency.

---
 rtl/shift_pkg.sv | 14 +
 rtl/lshift_step.sv | 24 ++
 rtl/seq_lshift_rot.sv | 94 +++++++++
 tb/tb_seq_lshift_rot.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the sequential left shifter/rotator.
package shift_pkg;

   localparam int WIDTH = 32;
   localparam int SHW   = 5;
   localparam int STEP  = 2;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/lshift_step.sv
// One combinational left step of 1 or 2 bits, logical or rotating.
module lshift_step #(
   parameter int WIDTH = shift_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] data,
   input  logic             two,
   input  logic             rotate,
   output logic [WIDTH-1:0] result
);

   logic [1:0] fill2;
   logic       fill1;

   always_comb begin
      fill2 = rotate ? data[WIDTH-1 -: 2] : 2'b00;
      fill1 = rotate ? data[WIDTH-1] : 1'b0;
      if (two) begin
         result = {data[WIDTH-3:0], fill2};
      end else begin
         result = {data[WIDTH-2:0], fill1};
      end
   end

endmodule

// File: rtl/seq_lshift_rot.sv
// Multi-cycle left shifter/rotator: 2 bits per clock, 1 on an odd tail.
module seq_lshift_rot #(
   parameter int WIDTH = shift_pkg::WIDTH,
   parameter int SHW   = shift_pkg::SHW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             rotate,
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out1
);

   import shift_pkg::*;

   state_t           state_q, state_d;
   logic [SHW-1:0]   rem_q, rem_d;
   logic             rot_q, rot_d;
   logic [WIDTH-1:0] out1_q, out1_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             two;
   logic [WIDTH-1:0] step_out;

   assign two = (rem_q >= SHW'(STEP));

   lshift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .data   (out1_q),
      .two    (two),
      .rotate (rot_q),
      .result (step_out)
   );

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      rot_d   = rot_q;
      out1_d  = out1_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               out1_d  = a;
               rem_d   = shamt;
               rot_d   = rotate;
               state_d = (shamt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            out1_d = step_out;
            rem_d  = two ? (rem_q - SHW'(STEP)) : '0;
            if (rem_d == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Status flags are registered from the next state so they align with it.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         rot_q   <= 1'b0;
         out1_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         rot_q   <= rot_d;
         out1_q  <= out1_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign out1 = out1_q;

endmodule

// File: tb/tb_seq_lshift_rot.sv
// Scoreboard bench for seq_lshift_rot with a randomized reference model.
module tb_seq_lshift_rot;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        rotate = 1'b0;
   logic [31:0] a = '0;
   logic [4:0]  shamt = '0;
   logic        busy;
   logic        done;
   logic [31:0] out1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [31:0] last = '0;

   typedef struct {
      logic [31:0] res;
      int          at;
   } exp_t;

   exp_t sb[$];

   seq_lshift_rot dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .rotate (rotate),
      .a      (a),
      .shamt  (shamt),
      .busy   (busy),
      .done   (done),
      .out1   (out1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] model(input logic [31:0] x,
                                         input int s, input bit r);
      logic [63:0] w;
      if (r) begin
         w = {x, x} << s;
         return w[63:32];
      end
      return x << s;
   endfunction

   task automatic check(input string n, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", n, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done cyc %0d out1 %h want none",
                     cyc, out1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", out1, e.res);
            check("latency", 32'(cyc), 32'(e.at));
         end
      end
   end

   task automatic wait_done(input bit jit);
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
         if (jit) begin
            a      = $urandom;
            shamt  = 5'($urandom);
            rotate = 1'($urandom);
            start  = 1'($urandom);
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout got none want done");
         if (sb.size() != 0) void'(sb.pop_front());
      end
   endtask

   task automatic push_exp(input logic [31:0] av, input int s,
                           input bit r);
      exp_t e;
      e.res = model(av, s, r);
      e.at  = cyc + (s + 1) / 2;
      sb.push_back(e);
      last = e.res;
   endtask

   task automatic run(input logic [31:0] av, input int s,
                      input bit r, input bit jit);
      a      = av;
      shamt  = 5'(s);
      rotate = r;
      start  = 1'b1;
      @(posedge clk);
      #1;
      push_exp(av, s, r);
      start = 1'b0;
      wait_done(jit);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("idle_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check("idle_hold", out1, last);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_out1", out1, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("idle_out1", out1, 32'd0);
         check("idle_flags", {30'd0, busy, done}, 32'd0);
      end

      run(32'h12345678, 4, 1'b0, 1'b0);
      run(32'hC0FFEE01, 5, 1'b1, 1'b0);
      run(32'h87654321, 4, 1'b1, 1'b0);
      run(32'hF0F0F0F0, 0, 1'b0, 1'b0);
      run(32'hABCDEFFF, 31, 1'b0, 1'b1);
      run(32'h0F0F0001, 31, 1'b1, 1'b1);

      // restart: start held through the done cycle and the one after it
      a = 32'h0F0F0001; shamt = 5'd3; rotate = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      push_exp(32'h0F0F0001, 3, 1'b1);
      start = 1'b0;
      wait_done(1'b0);
      a = 32'hDEADBEEF; shamt = 5'd7; rotate = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      a = 32'h13579BDF; shamt = 5'd9; rotate = 1'b1;
      @(posedge clk);
      #1;
      push_exp(32'h13579BDF, 9, 1'b1);
      start = 1'b0;
      wait_done(1'b0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 40; i++) begin
         run($urandom, int'($urandom_range(0, 31)), 1'($urandom),
             1'($urandom));
      end

      // reset two cycles into a long operation; no done may follow
      a = 32'hFFFF1234; shamt = 5'd20; rotate = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_out1", out1, 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      repeat (20) @(posedge clk);
      #1;

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
